// File: rtl/fifo_pkg.sv
// Matrix FIFO types: index/count widths and reader FSM encoding.
package fifo_pkg;

  localparam int MAX_N = 7;
  localparam int IDX_W = 3;
  localparam int CNT_W = 6;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] elem_cnt_t;

  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_WAIT_RDY = 2'd1,
    RD_STREAM   = 2'd2,
    RD_DONE     = 2'd3
  } rd_state_t;

  // N*N truncated to the element count width; legal N keeps it exact.
  function automatic elem_cnt_t square_cnt(input idx_t n);
    elem_cnt_t n_ext;
    n_ext = {{(CNT_W-IDX_W){1'b0}}, n};
    return elem_cnt_t'(n_ext * n_ext);
  endfunction

endpackage

// File: rtl/global_pkg.sv
// Shared base types used across the matrix datapath.
package global_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/mat_index_counter.sv
// Row/column/element counter walking an N x N matrix in row-major order.
module mat_index_counter
  import fifo_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      inc,
  input  idx_t      n,
  input  elem_cnt_t total,
  output idx_t      row,
  output idx_t      col,
  output logic      last_col,
  output logic      last,
  output elem_cnt_t cnt,
  output logic      exhausted
);

  idx_t      row_q, row_d;
  idx_t      col_q, col_d;
  elem_cnt_t cnt_q, cnt_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    cnt_d = cnt_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 6'd1;
      if (last_col) begin
        col_d = '0;
        row_d = row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
    end
  end

  assign row       = row_q;
  assign col       = col_q;
  assign cnt       = cnt_q;
  assign last_col  = (col_q == idx_t'(n - 3'd1));
  assign last      = (cnt_q == elem_cnt_t'(total - 6'd1));
  // Saturating guard: nothing may be popped once total elements are out.
  assign exhausted = (cnt_q >= total);

endmodule

// File: rtl/matrix_fifo_reader.sv
// Consumer side of the matrix FIFO: pops one N x N matrix row-major into a
// registered valid/accept output stage tagged with row/col and end markers.
module matrix_fifo_reader
  import global_pkg::*;
#(
  parameter int DW    = 8,
  parameter int MAX_N = fifo_pkg::MAX_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  nibble_t       N,
  input  logic          m_ready,
  input  logic          m_empty,
  input  logic [DW-1:0] m_data,
  output logic          m_pop,
  output logic          out_valid,
  input  logic          out_accept,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_row,
  output logic [2:0]    out_col,
  output logic          out_last_col,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [1:0] S_IDLE     = fifo_pkg::RD_IDLE;
  localparam logic [1:0] S_WAIT_RDY = fifo_pkg::RD_WAIT_RDY;
  localparam logic [1:0] S_STREAM   = fifo_pkg::RD_STREAM;
  localparam logic [1:0] S_DONE     = fifo_pkg::RD_DONE;

  logic [1:0]         state_q, state_d;
  fifo_pkg::idx_t     n_q, n_d;
  fifo_pkg::elem_cnt_t total_q, total_d;
  logic               error_q, error_d;

  logic               out_valid_q, out_valid_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  fifo_pkg::idx_t     out_row_q, out_row_d;
  fifo_pkg::idx_t     out_col_q, out_col_d;
  logic               out_last_col_q, out_last_col_d;
  logic               out_last_q, out_last_d;

  fifo_pkg::idx_t     idx_row, idx_col;
  fifo_pkg::elem_cnt_t idx_cnt;
  logic               idx_last_col, idx_last, idx_exhausted;

  logic               start_ok, n_legal, cnt_clear, pop, beat_acc;

  assign start_ok  = start && (state_q == S_IDLE);
  assign n_legal   = (N != 4'd0) && (32'(N) <= MAX_N);
  assign cnt_clear = start_ok && n_legal;
  assign beat_acc  = out_valid_q && out_accept;
  // Pop only when the output slot is free or being emptied this cycle.
  assign pop       = (state_q == S_STREAM) && !m_empty && !idx_exhausted &&
                     (!out_valid_q || out_accept);

  mat_index_counter u_idx (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .inc       (pop),
    .n         (n_q),
    .total     (total_q),
    .row       (idx_row),
    .col       (idx_col),
    .last_col  (idx_last_col),
    .last      (idx_last),
    .cnt       (idx_cnt),
    .exhausted (idx_exhausted)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    total_d = total_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if (n_legal) begin
            n_d     = fifo_pkg::idx_t'(N);
            total_d = fifo_pkg::square_cnt(fifo_pkg::idx_t'(N));
            error_d = FALSE;
            state_d = S_WAIT_RDY;
          end else begin
            error_d = TRUE;
          end
        end
      end
      S_WAIT_RDY: if (m_ready) state_d = S_STREAM;
      S_STREAM:   if (beat_acc && out_last_q) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_row_d      = out_row_q;
    out_col_d      = out_col_q;
    out_last_col_d = out_last_col_q;
    out_last_d     = out_last_q;
    if (pop) begin
      out_valid_d    = TRUE;
      out_data_d     = m_data;
      out_row_d      = idx_row;
      out_col_d      = idx_col;
      out_last_col_d = idx_last_col;
      out_last_d     = idx_last;
    end else if (beat_acc) begin
      out_valid_d    = FALSE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      total_q        <= '0;
      error_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      out_last_col_q <= 1'b0;
      out_last_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      total_q        <= total_d;
      error_q        <= error_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_row_q      <= out_row_d;
      out_col_q      <= out_col_d;
      out_last_col_q <= out_last_col_d;
      out_last_q     <= out_last_d;
    end
  end

  // The element count is only used internally for the exhaustion guard.
  logic unused_cnt;
  assign unused_cnt = ^idx_cnt;

  assign m_pop        = pop;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;
  assign out_last_col = out_last_col_q;
  assign out_last     = out_last_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign error        = error_q;

endmodule

// File: tb/tb_matrix_fifo_reader.sv
// Bench for matrix_fifo_reader: queue-modelled FIFO, row-major reference order.
module tb_matrix_fifo_reader;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    N = 4'd0;
  logic          m_ready = 1'b0;
  logic          m_empty = 1'b1;
  logic [DW-1:0] m_data = '0;
  logic          m_pop;
  logic          out_valid;
  logic          out_accept = 1'b0;
  logic [DW-1:0] out_data;
  logic [2:0]    out_row, out_col;
  logic          out_last_col, out_last, busy, done, error;

  always #5 clk = ~clk;

  matrix_fifo_reader #(.DW(DW), .MAX_N(7)) dut (
    .clk(clk), .rst(rst), .start(start), .N(N),
    .m_ready(m_ready), .m_empty(m_empty), .m_data(m_data), .m_pop(m_pop),
    .out_valid(out_valid), .out_accept(out_accept), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last_col(out_last_col),
    .out_last(out_last), .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    int n;
    int acc_mode;    // 0 always, 1 toggling, 2 random
    int gap_at;      // pops before forcing empty, -1 none
    int gap_len;
    int rdy_delay;
    int restart_at;  // beats before a stray start pulse, -1 none
    bit exp_err;
  } vec_t;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_data[$];
  int cur_n, beats, pops, viol, done_cnt, done_tick, tick_no;
  int last_beat_tick, first_beat_tick, first_pop_tick, first_valid_tick;
  bit force_empty, prev_stall;
  logic [15:0] prev_beat;

  task automatic chk(input string name, input int got, input int exp);
    total_cnt++;
    if (got != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic prepare(input int n, input int extra);
    fq.delete();
    exp_data.delete();
    for (int i = 0; i < n * n + extra; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      fq.push_back(v);
      if (i < n * n) exp_data.push_back(v);
    end
    cur_n = n; beats = 0; pops = 0; viol = 0; done_cnt = 0; done_tick = -1;
    last_beat_tick = -1; first_beat_tick = -1; first_pop_tick = -1;
    first_valid_tick = -1; prev_stall = 0; force_empty = 0;
  endtask

  // One cycle: drive FIFO model, sample mid-low-phase, advance past posedge.
  task automatic tick();
    logic s_pop, s_valid, s_acc;
    logic [15:0] cur;
    m_empty = force_empty || (fq.size() == 0);
    m_data  = (fq.size() != 0) ? fq[0] : '0;
    #1;
    s_pop   = m_pop;
    s_valid = out_valid;
    s_acc   = out_accept;
    cur     = {out_data, out_row, out_col, out_last_col, out_last};
    if (s_pop && m_empty) viol++;
    if (s_pop && s_valid && !s_acc) viol++;
    if (prev_stall) chk("hold", {15'd0, s_valid, cur}, {15'd0, 1'b1, prev_beat});
    if (s_valid && first_valid_tick < 0) first_valid_tick = tick_no;
    if (s_valid && s_acc) begin
      int k;
      k = beats;
      if (cur_n > 0 && k < exp_data.size()) begin
        logic [15:0] e;
        e = {exp_data[k], 3'(k / cur_n), 3'(k % cur_n),
             (k % cur_n) == cur_n - 1, k == cur_n * cur_n - 1};
        chk($sformatf("beat%0d", k), int'(cur), int'(e));
      end else begin
        chk("extra_beat", k, -1);
      end
      if (first_beat_tick < 0) first_beat_tick = tick_no;
      last_beat_tick = tick_no;
      beats++;
    end
    if (done) begin
      if (done_cnt > 0 || last_beat_tick != tick_no - 1) viol++;
      done_cnt++;
      done_tick = tick_no;
    end
    if (s_pop) begin
      pops++;
      if (first_pop_tick < 0) first_pop_tick = tick_no;
    end
    prev_stall = s_valid && !s_acc;
    prev_beat  = cur;
    @(posedge clk);
    if (s_pop && fq.size() != 0) void'(fq.pop_front());
    tick_no++;
    @(negedge clk);
  endtask

  task automatic run_transfer(input vec_t v);
    bit legal, restarted;
    int t0, gap_left;
    legal = (v.n >= 1 && v.n <= 7);
    prepare(legal ? v.n : 0, legal ? 2 : 4);
    gap_left   = v.gap_len;
    restarted  = 0;
    m_ready    = (v.rdy_delay == 0);
    out_accept = 1'b1;
    N          = 4'(v.n);
    start      = 1'b1;
    t0         = tick_no;
    tick();
    start = 1'b0;
    N     = 4'($urandom);
    chk("err_after_start", int'(error), int'(v.exp_err));
    chk("busy_after_start", int'(busy), int'(!v.exp_err));
    if (!legal) begin
      repeat (6) tick();
      chk("illegal_pops", pops, 0);
      chk("illegal_busy", int'(busy), 0);
      chk("illegal_err_sticky", int'(error), 1);
      $display("xfer n=%0d illegal err=%0d pops=%0d", v.n, error, pops);
      return;
    end
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      m_ready = (tick_no >= t0 + 1 + v.rdy_delay);
      case (v.acc_mode)
        0:       out_accept = 1'b1;
        1:       out_accept = tick_no[0];
        default: out_accept = 1'($urandom);
      endcase
      if (v.gap_at >= 0 && pops >= v.gap_at && gap_left > 0) begin
        force_empty = 1'b1;
        gap_left--;
      end else begin
        force_empty = 1'b0;
      end
      if (v.restart_at >= 0 && !restarted && beats == v.restart_at) begin
        start = 1'b1;
        N = 4'd5;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    force_empty = 1'b0;
    chk("done_seen", done_cnt, 1);
    tick();
    chk("done_once", done_cnt, 1);
    chk("idle_after", int'(busy), 0);
    chk("beats", beats, v.n * v.n);
    chk("pops", pops, v.n * v.n);
    chk("fifo_left", fq.size(), 2);
    chk("first_pop_lat", first_pop_tick - t0, 2 + v.rdy_delay);
    chk("pop_to_valid", first_valid_tick - first_pop_tick, 1);
    chk("done_lat", done_tick - last_beat_tick, 1);
    chk("protocol", viol, 0);
    if (v.acc_mode == 0 && v.gap_at < 0)
      chk("burst_len", last_beat_tick - first_beat_tick, v.n * v.n - 1);
    $display("xfer n=%0d mode=%0d beats=%0d pops=%0d cycles=%0d err=%0d",
             v.n, v.acc_mode, beats, pops, done_tick - t0, error);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3, 0, -1, 0, 0, -1, 1'b0};
    vecs[1]  = '{2, 1, -1, 0, 0, -1, 1'b0};
    vecs[2]  = '{0, 0, -1, 0, 0, -1, 1'b1};
    vecs[3]  = '{8, 0, -1, 0, 0, -1, 1'b1};
    vecs[4]  = '{3, 0, -1, 0, 0, -1, 1'b0};
    vecs[5]  = '{3, 0,  4, 5, 0, -1, 1'b0};
    vecs[6]  = '{3, 0, -1, 0, 0,  3, 1'b0};
    vecs[7]  = '{7, 2, -1, 0, 3, -1, 1'b0};
    vecs[8]  = '{1, 0, -1, 0, 0, -1, 1'b0};
    vecs[9]  = '{5, 2, 10, 3, 1, -1, 1'b0};
    vecs[10] = '{15, 0, -1, 0, 0, -1, 1'b1};

    tick_no = 0;
    #1 rst = 1'b0;
    #2;
    chk("rst_m_pop", int'(m_pop), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_row", int'(out_row), 0);
    chk("rst_col", int'(out_col), 0);
    chk("rst_last_col", int'(out_last_col), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_transfer(vecs[i]);

    // Reset in the middle of a 3x3 transfer, then a clean 2x2.
    prepare(3, 2);
    m_ready = 1'b1; out_accept = 1'b1; N = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && beats < 5; c++) tick();
    chk("rst_mid_beats", beats, 5);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_valid", int'(out_valid), 0);
    chk("rstmid_data", int'(out_data), 0);
    chk("rstmid_row", int'(out_row), 0);
    chk("rstmid_col", int'(out_col), 0);
    chk("rstmid_last_col", int'(out_last_col), 0);
    chk("rstmid_last", int'(out_last), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_m_pop", int'(m_pop), 0);
    $display("xfer reset mid-transfer after beats=%0d", beats);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_transfer('{2, 0, -1, 0, 0, -1, 1'b0});

    // Randomised legal transfers.
    repeat (6) begin
      vec_t v;
      v.n          = $urandom_range(1, 7);
      v.acc_mode   = 2;
      v.gap_at     = $urandom_range(0, v.n * v.n - 1);
      v.gap_len    = $urandom_range(1, 4);
      v.rdy_delay  = $urandom_range(0, 3);
      v.restart_at = -1;
      v.exp_err    = 1'b0;
      run_transfer(v);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/matrix_fifo_reader.md
# matrix_fifo_reader

Consumer side of the matrix FIFO. It waits until the write-side pointer logic reports that a full N×N matrix has been loaded, then pops exactly N·N elements in row-major order. Each element goes to the downstream multiply/accumulate datapath over a valid/accept handshake, tagged with its row/column index and with row-end and matrix-end markers. It sits between the matrix FIFO (memory plus pointer block) and the matrix-vector processing unit.

## Interface
Parameters:
- DW, 8, matrix element width in bits
- MAX_N, 7, largest legal matrix dimension; N·N must fit the 6-bit element count

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to read one matrix; ignored unless idle
- N  in  4  matrix dimension (nibble_t); sampled on accepted start
- m_ready  in  1  write side has pushed N·N elements
- m_empty  in  1  matrix FIFO empty
- m_data  in  DW  FIFO head data, valid whenever m_empty=0
- m_pop  out  1  pop strobe to FIFO pointer logic
- out_valid  out  1  out_data and tags valid
- out_accept  in  1  downstream takes the beat when out_valid=1
- out_data  out  DW  matrix element
- out_row  out  3  row index 0..N-1
- out_col  out  3  column index 0..N-1
- out_last_col  out  1  beat is the last element of its row
- out_last  out  1  beat is element N·N-1
- busy  out  1  transfer in progress (not IDLE)
- done  out  1  one-cycle pulse after the last beat is accepted
- error  out  1  sticky; illegal N on start; cleared by the next accepted start

## Operation
- States: IDLE, WAIT_RDY, STREAM, DONE.
- IDLE + start:
  - If N in 1..MAX_N: latch N and total = N·N (6-bit), clear row/col/pop count, clear error, go to WAIT_RDY.
  - Otherwise: set error, stay IDLE, no pops.
- WAIT_RDY: go to STREAM on the first cycle with m_ready=1.
- STREAM: m_pop = !m_empty && (pop_cnt < total) && (!out_valid || out_accept). m_pop is combinational and never asserted when m_empty=1.
- On pop:
  - out_data <= m_data; out_row/out_col <= current indices; out_valid <= 1.
  - out_last_col <= (col==N-1); out_last <= (pop_cnt==total-1).
  - col increments; at N-1 it wraps to 0 and row increments. pop_cnt increments.
- Beat accepted with no new pop: out_valid <= 0.
- Beat accepted with out_last=1: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in WAIT_RDY, STREAM and DONE. N changes after start have no effect.
- FIFO empty mid-stream: no pop, out_valid drops after the pending beat is accepted, then streaming resumes; the index sequence is unbroken.
- busy = (state != IDLE).

## Timing
- Reset values: m_pop=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last_col=0, out_last=0, busy=0, done=0, error=0; state IDLE; all counters 0.
- Reset mid-transfer returns to IDLE immediately. Elements already popped are lost; the FIFO pointers are reset by the same rst.
- Start to first m_pop: 1 cycle (into WAIT_RDY) plus m_ready wait plus 1 cycle (into STREAM). With m_ready already high, the first pop occurs 2 cycles after start.
- Pop to out_valid: 1 cycle (registered output stage).
- With m_empty=0 and out_accept=1, one beat per cycle. N·N beats take N·N consecutive cycles.
- out_data and tags are held stable while out_valid=1 and out_accept=0.
- done is asserted the cycle after the accepting edge of the out_last beat.
- Total pops per transfer is exactly total; never N·N+1.

## Structure
- fifo_pkg: MAX_N; idx_t (3-bit row/col index); elem_cnt_t (6-bit count); reader state enum rd_state_t.
- global_pkg: nibble_t, TRUE/FALSE (existing).
- Sub-module mat_index_counter: clear/inc inputs; row, col, last_col, last outputs; N and total inputs. Instantiated once. The FSM and output register stage stay in the top module.

## Test plan
- N=3, FIFO preloaded with 1..9, m_ready=1, out_accept=1 -> 9 consecutive beats with data 1..9, (row,col) = (0,0)..(2,2), out_last_col on data 3/6/9, out_last on 9, done 1 cycle later, exactly 9 pops.
- N=2, out_accept toggling 1,0,1,0 -> data 1..4 each held during stall cycles, no pop while the output is stalled, 4 pops total.
- N=0 and N=8 on start -> error=1, busy=0, m_pop never asserted; a following legal start clears error.
- N=3, m_empty forced high after 4 pops for 5 cycles -> out_valid drops, resumes at element 5 with (row,col)=(1,1); sequence complete.
- Reset asserted after 5 of 9 beats -> all outputs 0 asynchronously, state IDLE; a new start N=2 streams normally.
- start pulsed during STREAM with N=5 -> ignored; transfer completes with the original N=3 (9 beats).
